// File: rtl/bellek_port_hakemi.sv
// Round-robin sharing of one memory port between fetch (b) and data (v).
// Source FIFO routes responses back in order; fetch flush drops b responses.
module bellek_port_hakemi #(
  parameter int ADRES_BIT = 32,
  parameter int VERI_BIT  = 32,
  parameter int DERINLIK  = 4
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [ADRES_BIT-1:0]          b_istek_adres_i,
  input  logic                          b_istek_gecerli_i,
  output logic                          b_istek_hazir_o,
  output logic [VERI_BIT-1:0]           b_yanit_veri_o,
  output logic                          b_yanit_gecerli_o,
  input  logic                          b_yanit_hazir_i,
  input  logic                          b_bosalt_i,
  input  logic [ADRES_BIT-1:0]          v_istek_adres_i,
  input  logic [VERI_BIT-1:0]           v_istek_veri_i,
  input  logic [VERI_BIT/8-1:0]         v_istek_maske_i,
  input  logic                          v_istek_yaz_i,
  input  logic                          v_istek_gecerli_i,
  output logic                          v_istek_hazir_o,
  output logic [VERI_BIT-1:0]           v_yanit_veri_o,
  output logic                          v_yanit_gecerli_o,
  input  logic                          v_yanit_hazir_i,
  output logic [ADRES_BIT-1:0]          bel_istek_adres_o,
  output logic [VERI_BIT-1:0]           bel_istek_veri_o,
  output logic [VERI_BIT/8-1:0]         bel_istek_maske_o,
  output logic                          bel_istek_yaz_o,
  output logic                          bel_istek_gecerli_o,
  input  logic                          bel_istek_hazir_i,
  input  logic [VERI_BIT-1:0]           bel_yanit_veri_i,
  input  logic                          bel_yanit_gecerli_i,
  output logic                          bel_yanit_hazir_o,
  output logic [$clog2(DERINLIK):0]     bekleyen_sayisi_o
);

  localparam int PW = $clog2(DERINLIK);
  localparam int SW = PW + 1;
  localparam int MW = VERI_BIT / 8;
  localparam logic KAYNAK_B = 1'b0;
  localparam logic KAYNAK_V = 1'b1;

  typedef struct packed {
    logic [ADRES_BIT-1:0] adres;
    logic [VERI_BIT-1:0]  veri;
    logic [MW-1:0]        maske;
    logic                 yaz;
    logic                 kaynak;
    logic                 iptal;
  } ist_t;

  ist_t              ist_r;
  logic              ist_v_r;
  logic              son_kazanan_r;
  logic [SW-1:0]     bekleyen_r;
  logic [PW-1:0]     yaz_ptr_r;
  logic [PW-1:0]     oku_ptr_r;
  logic [DERINLIK-1:0] kaynak_r;
  logic [DERINLIK-1:0] iptal_r;

  logic          ist_cikis;
  logic [SW-1:0] fifo_sayi;
  logic          fifo_bos;
  logic          bas_kaynak;
  logic          bas_iptal;
  logic          yanit_al;
  logic          kabul_ok;
  logic          b_aday;
  logic          v_aday;
  logic          b_ver;
  logic          v_ver;
  logic          kabul;

  assign ist_cikis  = ist_v_r && bel_istek_hazir_i;
  assign fifo_sayi  = bekleyen_r - SW'(ist_v_r);
  assign fifo_bos   = (fifo_sayi == '0);
  assign bas_kaynak = kaynak_r[oku_ptr_r];
  assign bas_iptal  = iptal_r[oku_ptr_r];

  always_comb begin
    bel_yanit_hazir_o = 1'b0;
    b_yanit_gecerli_o = 1'b0;
    v_yanit_gecerli_o = 1'b0;
    if (!fifo_bos) begin
      unique case (1'b1)
        bas_iptal: bel_yanit_hazir_o = 1'b1;
        (!bas_iptal && bas_kaynak == KAYNAK_B): begin
          b_yanit_gecerli_o = bel_yanit_gecerli_i && !b_bosalt_i;
          bel_yanit_hazir_o = b_yanit_hazir_i || b_bosalt_i;
        end
        (!bas_iptal && bas_kaynak == KAYNAK_V): begin
          v_yanit_gecerli_o = bel_yanit_gecerli_i;
          bel_yanit_hazir_o = v_yanit_hazir_i;
        end
        default: ;
      endcase
    end
  end

  assign b_yanit_veri_o = b_yanit_gecerli_o ? bel_yanit_veri_i : '0;
  assign v_yanit_veri_o = v_yanit_gecerli_o ? bel_yanit_veri_i : '0;
  assign yanit_al = bel_yanit_gecerli_i && bel_yanit_hazir_o;

  // a pop in the same cycle frees the slot a full counter would block
  assign kabul_ok = rstn_i && (!ist_v_r || ist_cikis) &&
                    ((bekleyen_r < SW'(DERINLIK)) || yanit_al);
  assign b_aday = b_istek_gecerli_i && !b_bosalt_i;
  assign v_aday = v_istek_gecerli_i;
  assign b_ver  = kabul_ok && b_aday &&
                  (!v_aday || son_kazanan_r == KAYNAK_V);
  assign v_ver  = kabul_ok && v_aday &&
                  (!b_aday || son_kazanan_r == KAYNAK_B);
  assign kabul  = b_ver || v_ver;

  assign b_istek_hazir_o     = b_ver;
  assign v_istek_hazir_o     = v_ver;
  assign bel_istek_adres_o   = ist_r.adres;
  assign bel_istek_veri_o    = ist_r.veri;
  assign bel_istek_maske_o   = ist_r.maske;
  assign bel_istek_yaz_o     = ist_r.yaz;
  assign bel_istek_gecerli_o = ist_v_r;
  assign bekleyen_sayisi_o   = bekleyen_r;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ist_r         <= '0;
      ist_v_r       <= 1'b0;
      son_kazanan_r <= KAYNAK_V;
    end else if (b_ver) begin
      ist_r.adres   <= b_istek_adres_i;
      ist_r.veri    <= '0;
      ist_r.maske   <= '0;
      ist_r.yaz     <= 1'b0;
      ist_r.kaynak  <= KAYNAK_B;
      ist_r.iptal   <= 1'b0;
      ist_v_r       <= 1'b1;
      son_kazanan_r <= KAYNAK_B;
    end else if (v_ver) begin
      ist_r.adres   <= v_istek_adres_i;
      ist_r.veri    <= v_istek_veri_i;
      ist_r.maske   <= v_istek_maske_i;
      ist_r.yaz     <= v_istek_yaz_i;
      ist_r.kaynak  <= KAYNAK_V;
      ist_r.iptal   <= 1'b0;
      ist_v_r       <= 1'b1;
      son_kazanan_r <= KAYNAK_V;
    end else begin
      if (ist_cikis) ist_v_r <= 1'b0;
      if (b_bosalt_i && ist_r.kaynak == KAYNAK_B) ist_r.iptal <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      kaynak_r   <= '0;
      iptal_r    <= '0;
      yaz_ptr_r  <= '0;
      oku_ptr_r  <= '0;
      bekleyen_r <= '0;
    end else begin
      // b entries carry kaynak=0, so ~kaynak_r selects them
      if (b_bosalt_i) iptal_r <= iptal_r | ~kaynak_r;
      if (ist_cikis) begin
        kaynak_r[yaz_ptr_r] <= ist_r.kaynak;
        iptal_r[yaz_ptr_r]  <= ist_r.iptal ||
                               (b_bosalt_i && ist_r.kaynak == KAYNAK_B);
        yaz_ptr_r           <= yaz_ptr_r + PW'(1);
      end
      if (yanit_al) oku_ptr_r <= oku_ptr_r + PW'(1);
      bekleyen_r <= bekleyen_r + SW'(kabul) - SW'(yanit_al);
    end
  end

endmodule
